uart_tx_ctl: RTL and testbench
==============================

Name: uart_tx_ctl

Overview:
UART transmitter controller, the transmit-side counterpart of the RS232 receiver controller. It pulls characters from a first-word-fall-through character FIFO and serialises each one LSbit first onto txd as START, DATA, optional PARITY and STOP. Bit timing comes from the shared 16x baud enable, so one bit lasts 16 baud_x16_en ticks. It also drives the frame/bit observation signals used by the debug capture logic.

Parameters:
NUM_STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY_EN, 0, 1 inserts one parity bit after the MSbit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk_tx  input  1  transmit clock
rst_clk_tx  input  1  reset, active high, asynchronous
baud_x16_en  input  1  16x oversampling enable, one clk_tx cycle wide
char_fifo_empty  input  1  FIFO empty flag
char_fifo_dout  input  8  FIFO head data, valid while char_fifo_empty=0
char_fifo_rd_en  output  1  FIFO pop, one clk_tx cycle pulse
txd_tx  output  1  serial output, registered, idles high
tx_busy  output  1  high whenever state != IDLE
tx_store_qual  output  1  high while tx_frame_indicator != 00
tx_frame_indicator  output  2  00 = idle; alternates 01/10 on successive frames
tx_bit_indicator  output  1  high while state != IDLE and over_sample_cnt == 15 (first tick of each bit)

Behaviour:
- Reset: clk_tx and rst_clk_tx; reset is asynchronous, active high. On reset: state=IDLE, txd_tx=1, char_fifo_rd_en=0, tx_busy=0, tx_frame_indicator=00, internal old-indicator=10, over_sample_cnt=0, bit_cnt=0, shift register=0.
- Reset mid-frame: txd_tx returns to 1 immediately and the character in flight is discarded. The FIFO entry was already popped and is not re-sent.
- All state, counter and txd updates occur only on clk_tx edges with baud_x16_en=1, except char_fifo_rd_en, which clears on the next clk_tx edge regardless of the enable.
- States:
  - IDLE: txd_tx=1. On a tick with char_fifo_empty=0: capture char_fifo_dout into the shift register, pulse char_fifo_rd_en, set txd_tx<=0, over_sample_cnt<=15, go to START.
  - START: txd_tx=0 for 16 ticks. When over_sample_cnt==0: go to DATA, set bit_cnt<=0, txd_tx<=shift[0], over_sample_cnt<=15.
  - DATA: txd_tx=shift[bit_cnt] for 16 ticks per bit. At cnt==0 with bit_cnt<7: bit_cnt+1 and drive the next bit. At cnt==0 with bit_cnt==7: go to PARITY if PARITY_EN, else STOP.
  - PARITY: txd_tx = XOR of the 8 data bits, XOR PARITY_ODD, for 16 ticks, then go to STOP.
  - STOP: txd_tx=1 for 16*NUM_STOP_BITS ticks, using bit_cnt as the stop-bit counter. At the final cnt==0: if char_fifo_empty=0, load the next character, pulse char_fifo_rd_en and enter START directly (no idle gap); otherwise go to IDLE.
- Frame length: back-to-back 8N1 frames are exactly 160 ticks each. 8E2 frames are 192 ticks.
- Parity: computed from the captured shift register, never from the live char_fifo_dout.
- FIFO sampling: char_fifo_empty is sampled only on ticks in IDLE or at the end of STOP. A character arriving mid-frame waits for the frame to finish.
- Frame indicator:
  - On each START entry: indicator <= ~old and old <= ~old, giving 01, 10, 01, ...
  - On entry to IDLE: indicator <= 00.
  - A back-to-back START toggles the indicator directly between 01 and 10 without passing through 00.
- tx_busy is combinational from state and is high the cycle after the IDLE->START transition.

Test Plan:
- Reset while idle, then FIFO empty for 50 ticks -> txd_tx=1, rd_en never asserted, tx_frame_indicator=00, tx_busy=0.
- 8N1, FIFO holds 0xA5, one tick then empty -> one rd_en pulse; txd low 16 ticks, then data bits 1,0,1,0,0,1,0,1 at 16 ticks each, then high 16 ticks; IDLE at tick 160; indicator 01 then 00.
- 8N1, FIFO holds 0x00 then 0xFF back-to-back -> no idle gap; second START begins at tick 160; indicator goes 01 then 10 then 00; tx_bit_indicator gives exactly 20 one-tick pulses.
- PARITY_EN=1, PARITY_ODD=0, NUM_STOP_BITS=2, data 0x07 -> parity bit 1, stop high for 32 ticks, frame 192 ticks; repeat with PARITY_ODD=1 -> parity bit 0.
- Async reset asserted mid-DATA at bit 3 -> txd_tx=1 within the same cycle without waiting for a clk_tx edge; after release with FIFO holding 0x3C, the new frame transmits 0x3C cleanly.
- baud_x16_en held low for 100 cycles mid-frame -> txd_tx and state frozen; the frame resumes with no bit shortened.

Source files
------------

// File: rtl/uart_tx_ctl.sv
// rtl/uart_tx_ctl.sv - UART transmitter: FWFT char FIFO to LSbit-first serial frames on a 16x baud enable
module uart_tx_ctl #(
    parameter int NUM_STOP_BITS = 1,
    parameter int PARITY_EN     = 0,
    parameter int PARITY_ODD    = 0
) (
    input  logic       clk_tx,
    input  logic       rst_clk_tx,
    input  logic       baud_x16_en,
    input  logic       char_fifo_empty,
    input  logic [7:0] char_fifo_dout,
    output logic       char_fifo_rd_en,
    output logic       txd_tx,
    output logic       tx_busy,
    output logic       tx_store_qual,
    output logic [1:0] tx_frame_indicator,
    output logic       tx_bit_indicator
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [2:0] LAST_STOP = (NUM_STOP_BITS == 2) ? 3'd1 : 3'd0;

    logic [2:0] r_state;
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_txd;
    logic       r_rd_en;
    logic [1:0] r_frame_ind;
    logic [1:0] r_old_ind;

    logic [2:0] w_next_bit;
    logic       w_parity;
    logic       w_bit_done;

    assign w_next_bit = r_bit_cnt + 3'd1;
    // Parity comes from the captured character; the FIFO head may already hold the next one.
    assign w_parity   = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_bit_done = (r_os_cnt == 4'd0);

    always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
        if (rst_clk_tx) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_txd       <= 1'b1;
            r_rd_en     <= 1'b0;
            r_frame_ind <= 2'b00;
            r_old_ind   <= 2'b10;
        end else begin
            r_rd_en <= 1'b0;
            if (baud_x16_en) begin
                case (r_state)
                    S_IDLE: begin
                        r_txd <= 1'b1;
                        if (!char_fifo_empty) begin
                            r_shift     <= char_fifo_dout;
                            r_rd_en     <= 1'b1;
                            r_txd       <= 1'b0;
                            r_os_cnt    <= 4'd15;
                            r_state     <= S_START;
                            r_frame_ind <= ~r_old_ind;
                            r_old_ind   <= ~r_old_ind;
                        end
                    end
                    S_START: begin
                        if (w_bit_done) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                            r_txd     <= r_shift[0];
                            r_os_cnt  <= 4'd15;
                        end else begin
                            r_os_cnt <= r_os_cnt - 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_done) begin
                            r_os_cnt <= 4'd15;
                            if (r_bit_cnt != 3'd7) begin
                                r_bit_cnt <= w_next_bit;
                                r_txd     <= r_shift[w_next_bit];
                            end else if (PARITY_EN != 0) begin
                                r_state <= S_PARITY;
                                r_txd   <= w_parity;
                            end else begin
                                r_state   <= S_STOP;
                                r_bit_cnt <= 3'd0;
                                r_txd     <= 1'b1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt - 4'd1;
                        end
                    end
                    S_PARITY: begin
                        if (w_bit_done) begin
                            r_state   <= S_STOP;
                            r_bit_cnt <= 3'd0;
                            r_txd     <= 1'b1;
                            r_os_cnt  <= 4'd15;
                        end else begin
                            r_os_cnt <= r_os_cnt - 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (!w_bit_done) begin
                            r_os_cnt <= r_os_cnt - 4'd1;
                        end else if (r_bit_cnt != LAST_STOP) begin
                            r_bit_cnt <= w_next_bit;
                            r_os_cnt  <= 4'd15;
                        end else if (!char_fifo_empty) begin
                            // Back-to-back frame: straight into START, indicator flips 01<->10.
                            r_shift     <= char_fifo_dout;
                            r_rd_en     <= 1'b1;
                            r_txd       <= 1'b0;
                            r_os_cnt    <= 4'd15;
                            r_state     <= S_START;
                            r_frame_ind <= ~r_old_ind;
                            r_old_ind   <= ~r_old_ind;
                        end else begin
                            r_state     <= S_IDLE;
                            r_txd       <= 1'b1;
                            r_frame_ind <= 2'b00;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign char_fifo_rd_en    = r_rd_en;
    assign txd_tx             = r_txd;
    assign tx_busy            = (r_state != S_IDLE);
    assign tx_frame_indicator = r_frame_ind;
    assign tx_store_qual      = (r_frame_ind != 2'b00);
    assign tx_bit_indicator   = (r_state != S_IDLE) && (r_os_cnt == 4'd15);

endmodule

// File: tb/tb_uart_tx_ctl.sv
// tb/tb_uart_tx_ctl.sv - directed scoreboard bench for uart_tx_ctl (8N1, 8E2, 8O2 instances)
module tb_uart_tx_ctl;

    logic clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    logic       rst_clk_tx  = 1'b0;
    logic       baud_x16_en = 1'b0;
    logic       empty_r [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] dout_r  [3] = '{8'h00, 8'h00, 8'h00};
    logic       txd_w   [3];
    logic       rd_w    [3];
    logic       busy_w  [3];
    logic       sq_w    [3];
    logic       bi_w    [3];
    logic [1:0] fi_w    [3];

    uart_tx_ctl #(.NUM_STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx), .baud_x16_en(baud_x16_en),
        .char_fifo_empty(empty_r[0]), .char_fifo_dout(dout_r[0]), .char_fifo_rd_en(rd_w[0]),
        .txd_tx(txd_w[0]), .tx_busy(busy_w[0]), .tx_store_qual(sq_w[0]),
        .tx_frame_indicator(fi_w[0]), .tx_bit_indicator(bi_w[0]));

    uart_tx_ctl #(.NUM_STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx), .baud_x16_en(baud_x16_en),
        .char_fifo_empty(empty_r[1]), .char_fifo_dout(dout_r[1]), .char_fifo_rd_en(rd_w[1]),
        .txd_tx(txd_w[1]), .tx_busy(busy_w[1]), .tx_store_qual(sq_w[1]),
        .tx_frame_indicator(fi_w[1]), .tx_bit_indicator(bi_w[1]));

    uart_tx_ctl #(.NUM_STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk_tx(clk_tx), .rst_clk_tx(rst_clk_tx), .baud_x16_en(baud_x16_en),
        .char_fifo_empty(empty_r[2]), .char_fifo_dout(dout_r[2]), .char_fifo_rd_en(rd_w[2]),
        .txd_tx(txd_w[2]), .tx_busy(busy_w[2]), .tx_store_qual(sq_w[2]),
        .tx_frame_indicator(fi_w[2]), .tx_bit_indicator(bi_w[2]));

    int cfg_nstop [3] = '{1, 2, 2};
    int cfg_pen   [3] = '{0, 1, 1};
    int cfg_podd  [3] = '{0, 0, 1};

    int         checks      = 0;
    int         failures    = 0;
    int         sel         = 0;
    int         cyc_phase   = 0;
    int         tick_n      = 0;
    int         frame_len   = 160;
    int         last_pop    = 0;
    int         pop_count   = 0;
    int         bi_count    = 0;
    int         bit_tick    = 0;
    bit         freeze      = 1'b0;
    bit         mon_active  = 1'b0;
    bit         pending_end = 1'b0;
    logic [1:0] exp_old     = 2'b10;
    logic [7:0] fq [$];
    bit         exp_bits [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One scoreboard entry per bit time (16 ticks) of the frame.
    task automatic load_exp(input logic [7:0] ch);
        bit p;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(ch[i]);
        if (cfg_pen[sel] != 0) begin
            p = ((($countones(ch) % 2) == 1) != (cfg_podd[sel] != 0));
            exp_bits.push_back(p);
        end
        for (int i = 0; i < cfg_nstop[sel]; i++) exp_bits.push_back(1'b1);
    endtask

    task automatic update_fifo();
        empty_r[sel] = (fq.size() == 0);
        dout_r[sel]  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push_char(input logic [7:0] ch);
        fq.push_back(ch);
        update_fifo();
    endtask

    task automatic step();
        logic [7:0] ch;
        bit was_tick;
        was_tick    = !freeze && (cyc_phase == 3);
        baud_x16_en = was_tick;
        cyc_phase   = (cyc_phase + 1) % 4;
        @(posedge clk_tx);
        #1;
        if (was_tick) tick_n++;
        if (rd_w[sel] === 1'b1) begin
            pop_count++;
            chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) begin
                ch = fq.pop_front();
                load_exp(ch);
            end
            exp_old = ~exp_old;
            chk("frame_ind_start", 32'(fi_w[sel]), 32'(exp_old));
            chk("store_qual_start", 32'(sq_w[sel]), 32'd1);
            chk("busy_start", 32'(busy_w[sel]), 32'd1);
            if (pending_end) begin
                chk("b2b_frame_len", 32'(tick_n - last_pop), 32'(frame_len));
                pending_end = 1'b0;
            end
            last_pop = tick_n;
        end
        update_fifo();
        if (was_tick && !rst_clk_tx) begin
            if (bi_w[sel] === 1'b1) bi_count++;
            if (!mon_active && exp_bits.size() != 0) begin
                mon_active = 1'b1;
                bit_tick   = 0;
            end
            if (mon_active) begin
                chk("txd_bit", 32'(txd_w[sel]), 32'(exp_bits[0]));
                bit_tick++;
                if (bit_tick == 16) begin
                    bit_tick = 0;
                    void'(exp_bits.pop_front());
                    if (exp_bits.size() == 0) begin
                        mon_active  = 1'b0;
                        pending_end = 1'b1;
                    end
                end
            end else begin
                chk("txd_idle", 32'(txd_w[sel]), 32'd1);
                if (pending_end) begin
                    chk("frame_len", 32'(tick_n - last_pop), 32'(frame_len));
                    chk("busy_end", 32'(busy_w[sel]), 32'd0);
                    chk("frame_ind_end", 32'(fi_w[sel]), 32'd0);
                    chk("store_qual_end", 32'(sq_w[sel]), 32'd0);
                    pending_end = 1'b0;
                end
            end
        end
    endtask

    // Asserted mid-cycle so the outputs must react without a clock edge.
    task automatic do_reset();
        #2;
        rst_clk_tx = 1'b1;
        #1;
        chk("rst_txd", 32'(txd_w[sel]), 32'd1);
        chk("rst_busy", 32'(busy_w[sel]), 32'd0);
        chk("rst_rd_en", 32'(rd_w[sel]), 32'd0);
        chk("rst_frame_ind", 32'(fi_w[sel]), 32'd0);
        chk("rst_store_qual", 32'(sq_w[sel]), 32'd0);
        chk("rst_bit_ind", 32'(bi_w[sel]), 32'd0);
        exp_bits.delete();
        fq.delete();
        mon_active  = 1'b0;
        pending_end = 1'b0;
        bit_tick    = 0;
        exp_old     = 2'b10;
        update_fifo();
        repeat (3) step();
        rst_clk_tx = 1'b0;
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        while (!(fq.size() == 0 && exp_bits.size() == 0 && !mon_active && !pending_end)
               && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        int pc;
        logic held;

        // Reset while idle, then empty FIFO for 50+ ticks.
        do_reset();
        repeat (220) step();
        chk("idle_no_pop", 32'(pop_count), 32'd0);
        chk("idle_busy", 32'(busy_w[0]), 32'd0);
        chk("idle_frame_ind", 32'(fi_w[0]), 32'd0);

        // Single 8N1 frame of 0xA5.
        frame_len = 160;
        push_char(8'hA5);
        run_to_idle(2000);
        chk("a5_pops", 32'(pop_count), 32'd1);

        // Back-to-back 0x00, 0xFF with no idle gap.
        do_reset();
        pc       = pop_count;
        bi_count = 0;
        push_char(8'h00);
        push_char(8'hFF);
        run_to_idle(3000);
        chk("b2b_pops", 32'(pop_count - pc), 32'd2);
        chk("b2b_bit_ind", 32'(bi_count), 32'd20);

        // 8E2 then 8O2 with 0x07.
        frame_len = 192;
        sel = 1;
        do_reset();
        pc = pop_count;
        push_char(8'h07);
        run_to_idle(2000);
        chk("even_pops", 32'(pop_count - pc), 32'd1);
        sel = 2;
        do_reset();
        pc = pop_count;
        push_char(8'h07);
        run_to_idle(2000);
        chk("odd_pops", 32'(pop_count - pc), 32'd1);

        // Async reset in the middle of data bit 3, then a clean 0x3C frame.
        sel       = 0;
        frame_len = 160;
        do_reset();
        push_char(8'h81);
        n = 0;
        while (!(mon_active && exp_bits.size() == 6 && bit_tick == 8) && n < 2000) begin
            step();
            n++;
        end
        chk("bit3_timeout", 32'(n < 2000), 32'd1);
        chk("bit3_busy", 32'(busy_w[0]), 32'd1);
        do_reset();
        pc = pop_count;
        push_char(8'h3C);
        run_to_idle(2000);
        chk("post_rst_pops", 32'(pop_count - pc), 32'd1);

        // Baud enable held low mid-frame: everything freezes, then resumes intact.
        pc = pop_count;
        push_char(8'h96);
        n = 0;
        while (!(mon_active && exp_bits.size() == 5 && bit_tick == 5) && n < 2000) begin
            step();
            n++;
        end
        chk("freeze_timeout", 32'(n < 2000), 32'd1);
        held   = txd_w[0];
        freeze = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("freeze_txd", 32'(txd_w[0]), 32'(held));
            chk("freeze_busy", 32'(busy_w[0]), 32'd1);
        end
        freeze = 1'b0;
        run_to_idle(2000);
        chk("freeze_pops", 32'(pop_count - pc), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
